status_register_unit: RTL and testbench

Producer side of the processor's NZCV status path. Takes the EXE-stage ALU result, carry-out and overflow for each valid instruction, computes the flags, and holds the architectural status register `SR` that the condition-check logic consumes. Also provides a small LIFO of saved `SR` values for exception entry and return, with sticky overflow and underflow error flags. Sits between the EXE-stage ALU and the ID-stage condition check.

---
 rtl/status_register_unit.sv | 122 ++++++++++++
 tb/tb_status_register_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/status_register_unit.sv
// status_register_unit: NZCV flag producer and architectural status register,
// with a small LIFO of saved SR values for exception entry/return.
// SR is packed as {Z, C, N, V}.

module status_register_unit #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic                       s_bit,
  input  logic [3:0]                 exe_cmd,
  input  logic [31:0]                alu_res,
  input  logic                       alu_c,
  input  logic                       alu_v,
  input  logic                       freeze,
  input  logic                       flush,
  input  logic                       exc_entry,
  input  logic                       exc_return,
  output logic [3:0]                 SR,
  output logic                       sr_updated,
  output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
  output logic                       ovf_err,
  output logic                       unf_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;

  logic [3:0]    sr_q, sr_d;
  logic          sr_updated_q, sr_updated_d;
  logic [CW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [3:0]    lifo_q [DEPTH];

  logic          is_arith;
  logic [3:0]    flags;
  logic          upd;
  logic          push_ev, pop_ev;
  logic          push_ok, pop_ok;
  logic          full, empty;
  logic [3:0]    top;

  // Flag computation; logical commands carry C and V over from the current SR
  always_comb begin
    is_arith = (exe_cmd == CMD_ADD) || (exe_cmd == CMD_ADC) ||
               (exe_cmd == CMD_SUB) || (exe_cmd == CMD_SBC);
    flags[3] = (alu_res == 32'd0);
    flags[2] = is_arith ? alu_c : sr_q[2];
    flags[1] = alu_res[31];
    flags[0] = is_arith ? alu_v : sr_q[0];
  end

  // Top-of-LIFO select, written as a compare loop so the index never runs past DEPTH-1
  always_comb begin
    top = 4'b0000;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == CW'(i + 1)) top = lifo_q[i];
    end
  end

  // Event decode and next-state; a pop in the same cycle suppresses the push entirely
  always_comb begin
    full    = (depth_q == DEPTH_C);
    empty   = (depth_q == '0);
    upd     = valid & s_bit & ~flush & ~freeze;
    pop_ev  = exc_return & ~freeze;
    push_ev = exc_entry & ~exc_return & ~freeze;
    pop_ok  = pop_ev & ~empty;
    push_ok = push_ev & ~full;

    sr_d = sr_q;
    if (pop_ok)   sr_d = top;
    else if (upd) sr_d = flags;

    sr_updated_d = upd & ~pop_ok;

    depth_d = depth_q;
    if (push_ok)     depth_d = depth_q + CW'(1);
    else if (pop_ok) depth_d = depth_q - CW'(1);

    ovf_d = ovf_q | (push_ev & full);
    unf_d = unf_q | (pop_ev & empty);
  end

  // Architectural state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q         <= 4'b0000;
      sr_updated_q <= 1'b0;
      depth_q      <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      sr_updated_q <= sr_updated_d;
      depth_q      <= depth_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  // LIFO storage: the pre-update SR is written at the current depth on a successful push
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && push_ok && (depth_q == CW'(i))) lifo_q[i] <= sr_q;
    end
  end

  assign SR         = sr_q;
  assign sr_updated = sr_updated_q;
  assign depth_cnt  = depth_q;
  assign ovf_err    = ovf_q;
  assign unf_err    = unf_q;

endmodule

// File: tb/tb_status_register_unit.sv
// Directed bench for status_register_unit (DEPTH=2).

module tb_status_register_unit;

  logic        clk = 1'b0;
  logic        rst, valid, s_bit, alu_c, alu_v, freeze, flush, exc_entry, exc_return;
  logic [3:0]  exe_cmd;
  logic [31:0] alu_res;
  logic [3:0]  SR;
  logic        sr_updated, ovf_err, unf_err;
  logic [1:0]  depth_cnt;

  int checks = 0;
  int errors = 0;

  status_register_unit #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .valid(valid), .s_bit(s_bit), .exe_cmd(exe_cmd),
    .alu_res(alu_res), .alu_c(alu_c), .alu_v(alu_v), .freeze(freeze),
    .flush(flush), .exc_entry(exc_entry), .exc_return(exc_return),
    .SR(SR), .sr_updated(sr_updated), .depth_cnt(depth_cnt),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  task automatic clear();
    rst = 0; valid = 0; s_bit = 0; exe_cmd = 4'b0000; alu_res = 32'd0;
    alu_c = 0; alu_v = 0; freeze = 0; flush = 0; exc_entry = 0; exc_return = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd_in(input logic [3:0] cmd, input logic [31:0] res,
                        input logic c, input logic v);
    valid = 1; s_bit = 1; exe_cmd = cmd; alu_res = res; alu_c = c; alu_v = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear();
    #2;
    rst = 1;
    step();
    clear();
    check("rst_sr", 32'(SR), 32'h0);
    check("rst_upd", 32'(sr_updated), 32'h0);
    check("rst_depth", 32'(depth_cnt), 32'h0);
    check("rst_ovf", 32'(ovf_err), 32'h0);
    check("rst_unf", 32'(unf_err), 32'h0);

    // SUB with zero result and carry -> Z=1 C=1
    upd_in(4'b0100, 32'd0, 1, 0);
    step(); clear();
    check("sub_sr", 32'(SR), 32'hC);
    check("sub_upd", 32'(sr_updated), 32'h1);
    step();
    check("idle_upd", 32'(sr_updated), 32'h0);
    check("idle_sr", 32'(SR), 32'hC);

    // ADD negative with carry -> 0110
    upd_in(4'b0010, 32'h8000_0000, 1, 0);
    step(); clear();
    check("add_sr", 32'(SR), 32'h6);
    // logical: C, V kept
    upd_in(4'b0110, 32'h8000_0000, 0, 1);
    step(); clear();
    check("log_sr", 32'(SR), 32'h6);
    check("log_upd", 32'(sr_updated), 32'h1);

    // blocked updates
    upd_in(4'b0100, 32'd0, 0, 1); s_bit = 0;
    step(); clear();
    check("sbit0_sr", 32'(SR), 32'h6);
    check("sbit0_upd", 32'(sr_updated), 32'h0);
    upd_in(4'b0100, 32'd0, 0, 1); flush = 1;
    step(); clear();
    check("flush_sr", 32'(SR), 32'h6);
    check("flush_upd", 32'(sr_updated), 32'h0);
    upd_in(4'b0100, 32'd0, 0, 1); freeze = 1;
    step(); clear();
    check("frz_sr", 32'(SR), 32'h6);
    check("frz_upd", 32'(sr_updated), 32'h0);

    // LIFO: push A=0110
    exc_entry = 1;
    step(); clear();
    check("push1_depth", 32'(depth_cnt), 32'h1);
    // freeze blocks push
    exc_entry = 1; freeze = 1;
    step(); clear();
    check("frz_push_depth", 32'(depth_cnt), 32'h1);
    // B = 0001 via SUB res=1 c0 v1
    upd_in(4'b0100, 32'd1, 0, 1);
    step(); clear();
    check("b_sr", 32'(SR), 32'h1);
    exc_entry = 1;
    step(); clear();
    check("push2_depth", 32'(depth_cnt), 32'h2);
    check("push2_ovf", 32'(ovf_err), 32'h0);
    exc_entry = 1;
    step(); clear();
    check("push3_depth", 32'(depth_cnt), 32'h2);
    check("push3_ovf", 32'(ovf_err), 32'h1);
    exc_return = 1;
    step(); clear();
    check("pop1_sr", 32'(SR), 32'h1);
    check("pop1_depth", 32'(depth_cnt), 32'h1);
    exc_return = 1;
    step(); clear();
    check("pop2_sr", 32'(SR), 32'h6);
    check("pop2_depth", 32'(depth_cnt), 32'h0);
    exc_return = 1;
    step(); clear();
    check("pop3_unf", 32'(unf_err), 32'h1);
    check("pop3_sr", 32'(SR), 32'h6);
    check("pop3_depth", 32'(depth_cnt), 32'h0);

    // push T=0110, then upd F=1000 with pop -> pop wins
    exc_entry = 1;
    step(); clear();
    upd_in(4'b0100, 32'd0, 0, 0); exc_return = 1;
    step(); clear();
    check("popupd_sr", 32'(SR), 32'h6);
    check("popupd_upd", 32'(sr_updated), 32'h0);
    check("popupd_depth", 32'(depth_cnt), 32'h0);
    // push with upd: LIFO gets old SR, SR gets F
    upd_in(4'b0100, 32'd0, 0, 0); exc_entry = 1;
    step(); clear();
    check("pushupd_sr", 32'(SR), 32'h8);
    check("pushupd_upd", 32'(sr_updated), 32'h1);
    check("pushupd_depth", 32'(depth_cnt), 32'h1);
    exc_return = 1;
    step(); clear();
    check("pushupd_top", 32'(SR), 32'h6);
    // failed pop does not block upd
    upd_in(4'b0100, 32'd0, 0, 0); exc_return = 1;
    step(); clear();
    check("failpop_sr", 32'(SR), 32'h8);
    check("failpop_upd", 32'(sr_updated), 32'h1);

    // reset with depth=1, ovf=1, plus upd
    exc_entry = 1;
    step(); clear();
    check("pre_rst_depth", 32'(depth_cnt), 32'h1);
    rst = 1; upd_in(4'b0010, 32'h8000_0000, 1, 1);
    step(); clear();
    check("rst2_sr", 32'(SR), 32'h0);
    check("rst2_upd", 32'(sr_updated), 32'h0);
    check("rst2_depth", 32'(depth_cnt), 32'h0);
    check("rst2_ovf", 32'(ovf_err), 32'h0);
    check("rst2_unf", 32'(unf_err), 32'h0);

    // entry+return on full LIFO: only the pop happens, no overflow
    upd_in(4'b0100, 32'd5, 1, 0);  // SR=0100
    step(); clear();
    exc_entry = 1;
    step(); clear();
    exc_entry = 1;
    step(); clear();
    exc_entry = 1; exc_return = 1;
    step(); clear();
    check("both_depth", 32'(depth_cnt), 32'h1);
    check("both_ovf", 32'(ovf_err), 32'h0);
    check("both_sr", 32'(SR), 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
